console_text_writer: RTL and testbench

//   Upstream stage of the 100x30 text video RAM. Consumes a byte stream (UART RX / CPU),

---
 rtl/console_pkg.sv | 27 ++
 rtl/fill_sequencer.sv | 51 +++++
 rtl/console_text_writer.sv | 178 +++++++++++++++++
 tb/tb_console_text_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - char codes, default geometry and FSM states for the console text writer
package console_pkg;

  localparam int         DEF_COLS      = 100;
  localparam int         DEF_ROWS      = 30;
  localparam int         DEF_ADDR_W    = 12;
  localparam logic [7:0] DEF_FILL_CHAR = 8'h20;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_TAB      = 8'h09;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    S_CLR_ALL  = 2'd0,
    S_IDLE     = 2'd1,
    S_CLR_LINE = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/fill_sequencer.sv
// rtl/fill_sequencer.sv - walks len consecutive addresses from base, one per cycle
module fill_sequencer
  import console_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              en_o,
  output logic              done_o
);

  logic              active_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic              last;

  assign last = (cnt_q == len_q - ADDR_W'(1));

  // Latch base/len on start, then count 0..len-1 and drop back to idle with the counter cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
    end else if (!active_q) begin
      if (start_i) begin
        active_q <= 1'b1;
        cnt_q    <= '0;
        base_q   <= base_i;
        len_q    <= len_i;
      end
    end else if (last) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  assign addr_o = base_q + cnt_q;
  assign en_o   = active_q;
  assign done_o = active_q && last;

endmodule

// File: rtl/console_text_writer.sv
// rtl/console_text_writer.sv - byte stream to text video RAM writer with cursor; CONSOLE_AUTOWRAP_EN wraps at the last column
module console_text_writer
  import console_pkg::*;
#(
  parameter int         COLS      = DEF_COLS,
  parameter int         ROWS      = DEF_ROWS,
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data,
  output logic              w_en,
  output logic [4:0]        cur_row,
  output logic [6:0]        cur_col,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [4:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              w_en_q, w_en_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic              seq_start;
  logic [ADDR_W-1:0] seq_base, seq_len, seq_addr;
  logic              seq_en, seq_done;
  logic              adv;
  logic [7:0]        tab_next;
  logic [6:0]        tab_col;

  fill_sequencer #(.ADDR_W(ADDR_W)) u_fill (
    .clk     (clk),
    .rst     (rst),
    .start_i (seq_start),
    .base_i  (seq_base),
    .len_i   (seq_len),
    .addr_o  (seq_addr),
    .en_o    (seq_en),
    .done_o  (seq_done)
  );

  // Next tab stop is the next multiple of 8, clamped to the last column
  always_comb begin
    tab_next = {1'b0, col_q[6:3] + 4'd1, 3'b000};
    tab_col  = (tab_next >= 8'(COLS - 1)) ? 7'(COLS - 1) : tab_next[6:0];
  end

  // State register plus all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLR_ALL;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_en_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_en_q     <= w_en_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: drive clears through the sequencer, interpret accepted bytes in idle
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_en_d     = 1'b0;
    seq_start  = 1'b0;
    seq_base   = '0;
    seq_len    = '0;
    adv        = 1'b0;

    case (state_q)
      S_CLR_ALL, S_CLR_LINE: begin
        seq_start = !seq_en;
        seq_base  = (state_q == S_CLR_ALL) ? '0 : row_base_q;
        seq_len   = (state_q == S_CLR_ALL) ? ADDR_W'(COLS * ROWS) : ADDR_W'(COLS);
        if (seq_en) begin
          w_en_d   = 1'b1;
          w_addr_d = seq_addr;
          w_data_d = FILL_CHAR;
        end
        if (seq_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (is_printable(in_data)) begin
            w_en_d   = 1'b1;
            w_addr_d = row_base_q + ADDR_W'(col_q);
            w_data_d = in_data;
            if (col_q != 7'(COLS - 1)) begin
              col_d = col_q + 7'd1;
            end else begin
`ifdef CONSOLE_AUTOWRAP_EN
              col_d = '0;
              adv   = 1'b1;
`else
              col_d = col_q;
`endif
            end
          end else begin
            case (in_data)
              CH_CR:  col_d = '0;
              CH_LF: begin
                col_d = '0;
                adv   = 1'b1;
              end
              CH_BS: begin
                if (col_q != '0) begin
                  col_d    = col_q - 7'd1;
                  w_en_d   = 1'b1;
                  w_addr_d = row_base_q + ADDR_W'(col_q - 7'd1);
                  w_data_d = FILL_CHAR;
                end
              end
              CH_TAB: col_d = tab_col;
              CH_FF: begin
                row_d      = '0;
                col_d      = '0;
                row_base_d = '0;
                state_d    = S_CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = S_CLR_ALL;
    endcase

    // Row advance wraps to the top (no scroll) and always clears the new row
    if (adv) begin
      if (row_q == 5'(ROWS - 1)) begin
        row_d      = '0;
        row_base_d = '0;
      end else begin
        row_d      = row_q + 5'd1;
        row_base_d = row_base_q + ADDR_W'(COLS);
      end
      state_d = S_CLR_LINE;
    end

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign w_en     = w_en_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;

endmodule

// File: tb/tb_console_text_writer.sv
// tb/tb_console_text_writer.sv - directed self-checking bench for console_text_writer
module tb_console_text_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic        w_en;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [19:0] wq[$];
  logic [19:0] exp_q[$];

  console_text_writer dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_en     (w_en),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Log every RAM write
  always @(negedge clk) begin
    if (!rst && w_en) wq.push_back({w_addr, w_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic check_fill(input string tag, input int base, input int n);
    int errs = 0;
    logic [19:0] e;
    check({tag, "_cnt"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < wq.size() && i < n; i++) begin
      e = {12'(base + i), 8'h20};
      if (wq[i] !== e) errs++;
    end
    check({tag, "_data"}, 32'(errs), 32'd0);
    wq.delete();
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check({tag, "_row"}, 32'(cur_row), 32'(row));
    check({tag, "_col"}, 32'(cur_col), 32'(col));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"}, 32'(w_en), 32'd0);
    check({tag, "_waddr"}, 32'(w_addr), 32'd0);
    check({tag, "_wdata"}, 32'(w_data), 32'd0);
    check_cursor(tag, 0, 0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    logic [19:0] e;
    logic [7:0]  ch;
    int errs;
    int n;
    int rb;

    // 1. reset and power-up clear
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    wait_idle(4000);
    settle();
    check_fill("clr_all", 0, 3000);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // 2. "AB", then CR LF
    send(8'h41);
    send(8'h42);
    settle();
    check("ab_n", 32'(wq.size()), 32'd2);
    e = {12'd0, 8'h41};
    check("ab_w0", 32'(wq[0]), 32'(e));
    e = {12'd1, 8'h42};
    check("ab_w1", 32'(wq[1]), 32'(e));
    check_cursor("ab", 0, 2);
    wq.delete();
    send(8'h0D);
    settle();
    check("cr_nowrite", 32'(wq.size()), 32'd0);
    check_cursor("cr", 0, 0);
    send(8'h0A);
    wait_idle(400);
    settle();
    check_cursor("lf", 1, 0);
    check_fill("lf", 100, 100);

    // 3. backspace at col 2 and col 0
    send(8'h78);
    send(8'h79);
    settle();
    wq.delete();
    send(8'h08);
    settle();
    check("bs_n", 32'(wq.size()), 32'd1);
    e = {12'd101, 8'h20};
    check("bs_w", 32'(wq[0]), 32'(e));
    check_cursor("bs", 1, 1);
    wq.delete();
    send(8'h0D);
    send(8'h08);
    settle();
    check("bs0_nowrite", 32'(wq.size()), 32'd0);
    check_cursor("bs0", 1, 0);

    // 4. FF then 101 printables from (0,0)
    send(8'h0C);
    wait_idle(4000);
    settle();
    check_fill("ff1", 0, 3000);
    check_cursor("ff1", 0, 0);
    for (int i = 0; i < 101; i++) send(8'h21 + 8'(i % 90));
    wait_idle(400);
    settle();
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back({12'(i), 8'h21 + 8'(i % 90)});
`ifdef CONSOLE_AUTOWRAP_EN
    for (int i = 0; i < 100; i++) exp_q.push_back({12'(100 + i), 8'h20});
    exp_q.push_back({12'd100, 8'h21 + 8'd10});
`else
    exp_q.push_back({12'd99, 8'h21 + 8'd10});
`endif
    check("line_n", 32'(wq.size()), 32'(exp_q.size()));
    errs = 0;
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      if (wq[i] !== exp_q[i]) errs++;
    check("line_data", 32'(errs), 32'd0);
    wq.delete();
`ifdef CONSOLE_AUTOWRAP_EN
    check_cursor("line", 1, 1);
    rb = 100;
`else
    check_cursor("line", 0, 99);
    rb = 0;
`endif

    // TAB stops, saturation, dropped codes
    send(8'h0D);
    send(8'h09);
    settle();
    check_cursor("tab8", rb / 100, 8);
    send(8'h61);
    send(8'h09);
    settle();
    check_cursor("tab16", rb / 100, 16);
    check("tab_n", 32'(wq.size()), 32'd1);
    e = {12'(rb + 8), 8'h61};
    check("tab_w", 32'(wq[0]), 32'(e));
    wq.delete();
    send(8'h0D);
    for (int i = 0; i < 12; i++) send(8'h09);
    settle();
    check_cursor("tab96", rb / 100, 96);
    send(8'h09);
    settle();
    check_cursor("tabsat", rb / 100, 99);
    send(8'h7F);
    send(8'h01);
    settle();
    check_cursor("drop", rb / 100, 99);
    check("drop_nowrite", 32'(wq.size()), 32'd0);

    // 5. LF on the last row wraps to the top and clears row 0
    n = 0;
    while (cur_row != 5'd29 && n < 40) begin
      send(8'h0A);
      wait_idle(400);
      n++;
    end
    settle();
    check("reach_r29", 32'(cur_row), 32'd29);
    wq.delete();
    send(8'h0A);
    wait_idle(400);
    settle();
    check_cursor("wrap", 0, 0);
    check_fill("wrap", 0, 100);

    // FF mid-stream
    send(8'h51);
    send(8'h52);
    send(8'h0C);
    wait_idle(4000);
    settle();
    check("ff2_n", 32'(wq.size()), 32'd3002);
    e = {12'd0, 8'h51};
    check("ff2_w0", 32'(wq.pop_front()), 32'(e));
    e = {12'd1, 8'h52};
    check("ff2_w1", 32'(wq.pop_front()), 32'(e));
    check_fill("ff2", 0, 3000);
    check_cursor("ff2", 0, 0);

    // 6. reset during a line clear, with in_valid held high while busy
    send(8'h0A);
    repeat (30) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst2");
    repeat (3) @(negedge clk);
    wq.delete();
    rst = 1'b0;
    n = 0;
    errs = 0;
    @(negedge clk);
    while (!in_ready && n < 4000) begin
      if (busy && in_ready) errs++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("rst2_ready", 32'(in_ready), 32'd1);
    check("rst2_overlap", 32'(errs), 32'd0);
    settle();
    check_fill("rst2", 0, 3000);
    check_cursor("rst2_end", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
